// File: rtl/cpu_phase_sequencer.sv
// rtl/cpu_phase_sequencer.sv - multi-cycle FETCH/DECODE/EXEC/MEM/WB phase controller
// Optional macro PHASE_PERF_CNT_EN enables cycle_cnt/instret_cnt; otherwise they read 0.
module cpu_phase_sequencer #(
  parameter int MEM_WAIT_MAX = 15,
  parameter int CNT_W        = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             run,
  input  logic             imem_ready,
  input  logic [31:0]      imem_rdata,
  input  logic             is_load,
  input  logic             is_store,
  input  logic             is_halt,
  input  logic             is_illegal,
  input  logic             dmem_ready,
  output logic             imem_req,
  output logic [31:0]      instr,
  output logic             en_fetch_pulse,
  output logic             en_exe_pulse,
  output logic             dmem_req,
  output logic             dmem_we,
  output logic             halted,
  output logic             fault,
  output logic [1:0]       fault_code,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instret_cnt
);

  localparam int WAIT_W = (MEM_WAIT_MAX > 0) ? $clog2(MEM_WAIT_MAX + 1) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST =
    (MEM_WAIT_MAX > 0) ? WAIT_W'(MEM_WAIT_MAX - 1) : '0;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALTED = 3'd6,
    S_FAULT  = 3'd7
  } phase_t;

  phase_t            state_q;
  phase_t            state_d;
  logic [WAIT_W-1:0] wait_cnt;
  logic              in_wait;
  logic              mem_ready;
  logic              wait_expired;
  logic [1:0]        fault_code_d;

  assign state     = state_q;
  assign in_wait   = (state_q == S_FETCH) || (state_q == S_MEM);
  assign mem_ready = (state_q == S_FETCH) ? imem_ready : dmem_ready;
  // Expires on the last permitted low cycle, so FAULT is entered on the following edge.
  assign wait_expired = (MEM_WAIT_MAX != 0) && in_wait && !mem_ready && (wait_cnt == WAIT_LAST);

  always_comb begin
    state_d      = state_q;
    fault_code_d = 2'b00;
    case (state_q)
      S_IDLE:   if (run) state_d = S_FETCH;
      S_FETCH: begin
        if (imem_ready) begin
          state_d = S_DECODE;
        end else if (wait_expired) begin
          state_d      = S_FAULT;
          fault_code_d = 2'b01;
        end
      end
      S_DECODE: begin
        if (is_illegal) begin
          state_d      = S_FAULT;
          fault_code_d = 2'b11;
        end else if (is_halt) begin
          state_d = S_HALTED;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC:   state_d = (is_load || is_store) ? S_MEM : S_WB;
      S_MEM: begin
        if (dmem_ready) begin
          state_d = S_WB;
        end else if (wait_expired) begin
          state_d      = S_FAULT;
          fault_code_d = 2'b10;
        end
      end
      S_WB:     state_d = run ? S_FETCH : S_IDLE;
      default:  state_d = state_q;
    endcase
  end

  // Outputs are registered from the next state so they line up with the state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= S_IDLE;
      wait_cnt       <= '0;
      instr          <= '0;
      imem_req       <= 1'b0;
      en_fetch_pulse <= 1'b0;
      en_exe_pulse   <= 1'b0;
      dmem_req       <= 1'b0;
      dmem_we        <= 1'b0;
      halted         <= 1'b0;
      fault          <= 1'b0;
      fault_code     <= 2'b00;
    end else begin
      state_q <= state_d;

      if (state_d != state_q) begin
        wait_cnt <= '0;
      end else if (in_wait && !mem_ready) begin
        wait_cnt <= wait_cnt + WAIT_W'(1);
      end

      if (state_q == S_FETCH && imem_ready) begin
        instr <= imem_rdata;
      end

      imem_req       <= (state_d == S_FETCH);
      en_fetch_pulse <= (state_d == S_DECODE);
      en_exe_pulse   <= (state_d == S_WB);
      dmem_req       <= (state_d == S_MEM);
      halted         <= (state_d == S_HALTED);
      fault          <= (state_d == S_FAULT);

      if (state_d != S_MEM) begin
        dmem_we <= 1'b0;
      end else if (state_q == S_EXEC) begin
        dmem_we <= is_store;
      end

      if (state_d == S_FAULT && state_q != S_FAULT) begin
        fault_code <= fault_code_d;
      end
    end
  end

`ifdef PHASE_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      cycle_cnt   <= '0;
      instret_cnt <= '0;
    end else begin
      cycle_cnt <= cycle_cnt + CNT_W'(1);
      if (state_q == S_WB) begin
        instret_cnt <= instret_cnt + CNT_W'(1);
      end
    end
  end
`else
  assign cycle_cnt   = '0;
  assign instret_cnt = '0;
`endif

endmodule

// File: tb/tb_cpu_phase_sequencer.sv
// tb/tb_cpu_phase_sequencer.sv - directed vector bench for cpu_phase_sequencer
module tb_cpu_phase_sequencer;

`ifdef PHASE_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  localparam logic [2:0] IDLE = 3'd0, FETCH = 3'd1, DECODE = 3'd2, EXEC = 3'd3,
                         MEM = 3'd4, WB = 3'd5, HALTED = 3'd6, FAULT = 3'd7;

  logic        clk = 1'b0;
  logic        reset, run, imem_ready, is_load, is_store, is_halt, is_illegal, dmem_ready;
  logic [31:0] imem_rdata;
  logic        imem_req, en_fetch_pulse, en_exe_pulse, dmem_req, dmem_we, halted, fault;
  logic [31:0] instr;
  logic [1:0]  fault_code;
  logic [2:0]  state;
  logic [31:0] cycle_cnt, instret_cnt;

  int checks = 0;
  int errors = 0;

  cpu_phase_sequencer #(.MEM_WAIT_MAX(15), .CNT_W(32)) dut (
    .clk(clk), .reset(reset), .run(run), .imem_ready(imem_ready), .imem_rdata(imem_rdata),
    .is_load(is_load), .is_store(is_store), .is_halt(is_halt), .is_illegal(is_illegal),
    .dmem_ready(dmem_ready), .imem_req(imem_req), .instr(instr),
    .en_fetch_pulse(en_fetch_pulse), .en_exe_pulse(en_exe_pulse), .dmem_req(dmem_req),
    .dmem_we(dmem_we), .halted(halted), .fault(fault), .fault_code(fault_code),
    .state(state), .cycle_cnt(cycle_cnt), .instret_cnt(instret_cnt)
  );

  always #5 clk = ~clk;

  // flags order: {imem_req, en_fetch_pulse, en_exe_pulse, dmem_req, dmem_we, halted, fault}
  typedef struct {
    logic        rst, rn, ir;
    logic [31:0] rdata;
    logic        ld, st, hlt, ill, dr;
    logic [2:0]  e_state;
    logic [6:0]  e_flags;
    logic [1:0]  e_fc;
    logic [31:0] e_instr;
    logic [31:0] e_instret;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic rst, rn, ir, input logic [31:0] rdata,
                              input logic ld, st, hlt, ill, dr,
                              input logic [2:0] es, input logic [6:0] ef, input logic [1:0] efc,
                              input logic [31:0] ei, input logic [31:0] eret);
    vec_t v;
    v.rst = rst; v.rn = rn; v.ir = ir; v.rdata = rdata;
    v.ld = ld; v.st = st; v.hlt = hlt; v.ill = ill; v.dr = dr;
    v.e_state = es; v.e_flags = ef; v.e_fc = efc; v.e_instr = ei;
    v.e_instret = PERF ? eret : 32'd0;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic drive(input logic rst, rn, ir, input logic [31:0] rdata,
                       input logic ld, st, hlt, ill, dr);
    reset = rst; run = rn; imem_ready = ir; imem_rdata = rdata;
    is_load = ld; is_store = st; is_halt = hlt; is_illegal = ill; dmem_ready = dr;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [6:0] flags();
    return {imem_req, en_fetch_pulse, en_exe_pulse, dmem_req, dmem_we, halted, fault};
  endfunction

  initial begin
    //                 rst rn ir rdata        ld st hl il dr   state   flags       fc  instr        instret
    vecs.push_back(mk(1, 0, 0, 32'h0,        0, 0, 0, 0, 0,  IDLE,   7'b0000000, 0, 32'h0,        0));
    vecs.push_back(mk(0, 1, 0, 32'h0,        0, 0, 0, 0, 0,  FETCH,  7'b1000000, 0, 32'h0,        0));
    vecs.push_back(mk(0, 1, 1, 32'h00000033, 0, 0, 0, 0, 0,  DECODE, 7'b0100000, 0, 32'h00000033, 0));
    vecs.push_back(mk(0, 1, 0, 32'h0,        0, 0, 0, 0, 0,  EXEC,   7'b0000000, 0, 32'h00000033, 0));
    vecs.push_back(mk(0, 1, 0, 32'h0,        0, 0, 0, 0, 0,  WB,     7'b0010000, 0, 32'h00000033, 0));
    vecs.push_back(mk(0, 1, 0, 32'h0,        0, 0, 0, 0, 0,  FETCH,  7'b1000000, 0, 32'h00000033, 1));
    vecs.push_back(mk(0, 1, 1, 32'h00002003, 0, 0, 0, 0, 0,  DECODE, 7'b0100000, 0, 32'h00002003, 1));
    vecs.push_back(mk(0, 1, 0, 32'h0,        1, 0, 0, 0, 0,  EXEC,   7'b0000000, 0, 32'h00002003, 1));
    vecs.push_back(mk(0, 1, 0, 32'h0,        1, 0, 0, 0, 0,  MEM,    7'b0001000, 0, 32'h00002003, 1));
    vecs.push_back(mk(0, 1, 0, 32'h0,        1, 0, 0, 0, 0,  MEM,    7'b0001000, 0, 32'h00002003, 1));
    vecs.push_back(mk(0, 1, 0, 32'h0,        1, 0, 0, 0, 0,  MEM,    7'b0001000, 0, 32'h00002003, 1));
    vecs.push_back(mk(0, 1, 0, 32'h0,        1, 0, 0, 0, 0,  MEM,    7'b0001000, 0, 32'h00002003, 1));
    vecs.push_back(mk(0, 1, 0, 32'h0,        1, 0, 0, 0, 1,  WB,     7'b0010000, 0, 32'h00002003, 1));
    vecs.push_back(mk(0, 1, 0, 32'h0,        0, 0, 0, 0, 0,  FETCH,  7'b1000000, 0, 32'h00002003, 2));
    vecs.push_back(mk(0, 1, 1, 32'h00002023, 0, 0, 0, 0, 0,  DECODE, 7'b0100000, 0, 32'h00002023, 2));
    vecs.push_back(mk(0, 1, 0, 32'h0,        0, 1, 0, 0, 0,  EXEC,   7'b0000000, 0, 32'h00002023, 2));
    vecs.push_back(mk(0, 0, 0, 32'h0,        0, 1, 0, 0, 0,  MEM,    7'b0001100, 0, 32'h00002023, 2));
    vecs.push_back(mk(0, 0, 0, 32'h0,        0, 1, 0, 0, 1,  WB,     7'b0010000, 0, 32'h00002023, 2));
    vecs.push_back(mk(0, 0, 0, 32'h0,        0, 0, 0, 0, 0,  IDLE,   7'b0000000, 0, 32'h00002023, 3));
    vecs.push_back(mk(0, 0, 1, 32'hDEADBEEF, 0, 0, 0, 0, 0,  IDLE,   7'b0000000, 0, 32'h00002023, 3));
    vecs.push_back(mk(0, 1, 0, 32'h0,        0, 0, 0, 0, 0,  FETCH,  7'b1000000, 0, 32'h00002023, 3));
    vecs.push_back(mk(0, 1, 1, 32'h00100073, 0, 0, 0, 0, 0,  DECODE, 7'b0100000, 0, 32'h00100073, 3));
    vecs.push_back(mk(0, 1, 0, 32'h0,        0, 0, 1, 0, 0,  HALTED, 7'b0000010, 0, 32'h00100073, 3));
    vecs.push_back(mk(0, 1, 1, 32'h0,        0, 0, 1, 0, 1,  HALTED, 7'b0000010, 0, 32'h00100073, 3));
    vecs.push_back(mk(1, 0, 0, 32'h0,        0, 0, 0, 0, 0,  IDLE,   7'b0000000, 0, 32'h0,        0));

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].rst, vecs[i].rn, vecs[i].ir, vecs[i].rdata,
            vecs[i].ld, vecs[i].st, vecs[i].hlt, vecs[i].ill, vecs[i].dr);
      chk($sformatf("vec%0d state", i),   {29'd0, state},       {29'd0, vecs[i].e_state});
      chk($sformatf("vec%0d flags", i),   {25'd0, flags()},     {25'd0, vecs[i].e_flags});
      chk($sformatf("vec%0d fcode", i),   {30'd0, fault_code},  {30'd0, vecs[i].e_fc});
      chk($sformatf("vec%0d instr", i),   instr,                vecs[i].e_instr);
      chk($sformatf("vec%0d instret", i), instret_cnt,          vecs[i].e_instret);
    end

    // imem timeout: 15 consecutive low FETCH cycles fault on the 15th edge
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
    drive(0, 1, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 14; i++) begin
      drive(0, 1, 0, 0, 0, 0, 0, 0, 0);
      chk($sformatf("tmo wait%0d state", i), {29'd0, state}, {29'd0, FETCH});
    end
    drive(0, 1, 0, 0, 0, 0, 0, 0, 0);
    chk("tmo state", {29'd0, state}, {29'd0, FAULT});
    chk("tmo flags", {25'd0, flags()}, 32'b0000001);
    chk("tmo fcode", {30'd0, fault_code}, 32'd1);
    drive(0, 1, 1, 32'h12345678, 0, 0, 0, 0, 1);
    chk("tmo late ready state", {29'd0, state}, {29'd0, FAULT});
    chk("tmo late ready instr", instr, 32'h0);
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("tmo reset state", {29'd0, state}, {29'd0, IDLE});
    chk("tmo reset flags", {25'd0, flags()}, 32'd0);
    chk("tmo reset fcode", {30'd0, fault_code}, 32'd0);

    // ready on the 15th FETCH cycle is still accepted
    drive(0, 1, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 14; i++) drive(0, 1, 0, 0, 0, 0, 0, 0, 0);
    drive(0, 1, 1, 32'h00000013, 0, 0, 0, 0, 0);
    chk("late accept state", {29'd0, state}, {29'd0, DECODE});
    chk("late accept instr", instr, 32'h00000013);

    // illegal wins over halt
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
    drive(0, 1, 0, 0, 0, 0, 0, 0, 0);
    drive(0, 1, 1, 32'hFFFFFFFF, 0, 0, 0, 0, 0);
    drive(0, 1, 0, 0, 0, 0, 1, 1, 0);
    chk("illegal state", {29'd0, state}, {29'd0, FAULT});
    chk("illegal flags", {25'd0, flags()}, 32'b0000001);
    chk("illegal fcode", {30'd0, fault_code}, 32'd3);

    // reset while a load is in MEM
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
    drive(0, 1, 0, 0, 0, 0, 0, 0, 0);
    drive(0, 1, 1, 32'h00002003, 0, 0, 0, 0, 0);
    drive(0, 1, 0, 0, 1, 0, 0, 0, 0);
    drive(0, 1, 0, 0, 1, 0, 0, 0, 0);
    chk("rst-mem dmem_req", {31'd0, dmem_req}, 32'd1);
    chk("rst-mem cycle_cnt", cycle_cnt, PERF ? 32'd4 : 32'd0);
    drive(1, 1, 0, 0, 1, 0, 0, 0, 0);
    chk("rst-mem after dmem_req", {31'd0, dmem_req}, 32'd0);
    chk("rst-mem after state", {29'd0, state}, {29'd0, IDLE});
    chk("rst-mem after cycle_cnt", cycle_cnt, 32'd0);
    chk("rst-mem after instret", instret_cnt, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cpu_phase_sequencer.md
# cpu_phase_sequencer

Parametrised multi-cycle phase controller for the RISC-V CPU core, successor to the fixed fetch/execute pulse generation inside the control unit. Sequences each instruction through FETCH, DECODE, EXEC, optional MEM, and WB. Adds ready-based wait states on instruction and data memory, timeout faults, halt and illegal-instruction handling, and optional performance counters. Sits between the CPU top, instruction/data memories, Control_Unit decode and Datapath commit.

## Interface
Parameters:
- `MEM_WAIT_MAX`, default 15: maximum consecutive ready-low cycles in FETCH or MEM before FAULT. 0 disables the timeout.
- `CNT_W`, default 32: width of the performance counters.

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1  system clock
- `reset`  in  1  synchronous, active-high
- `run`  in  1  level; permits starting a new instruction
- `imem_ready`  in  1  instruction memory data valid
- `imem_rdata`  in  32  instruction word
- `is_load`, `is_store`, `is_halt`, `is_illegal`  in  1 each  decode of `instr`, valid from DECODE onward
- `dmem_ready`  in  1  data access complete
- `imem_req`  out  1  instruction fetch request
- `instr`  out  32  latched instruction register
- `en_fetch_pulse`  out  1  one-cycle pulse: new `instr` valid
- `en_exe_pulse`  out  1  one-cycle commit pulse (register write, PC update)
- `dmem_req`  out  1  data memory request
- `dmem_we`  out  1  store when high, load when low; valid only with `dmem_req`
- `halted`  out  1  sticky halt
- `fault`  out  1  sticky fault
- `fault_code`  out  2  01 imem timeout, 10 dmem timeout, 11 illegal
- `state`  out  3  encoded FSM state, for debug probing
- `cycle_cnt`, `instret_cnt`  out  CNT_W  performance counters

## Operation
States: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, HALTED=6, FAULT=7.
- IDLE: `run`=1 → FETCH.
- FETCH: `imem_req`=1.
  - `imem_ready`=1: latch `imem_rdata` into `instr`, → DECODE.
  - Timeout: → FAULT, code 01.
- DECODE: `en_fetch_pulse`=1.
  - `is_illegal` → FAULT, code 11. Illegal wins over halt.
  - Else `is_halt` → HALTED.
  - Else → EXEC.
- EXEC: one cycle.
  - `is_load|is_store` → MEM.
  - Else → WB.
- MEM: `dmem_req`=1, `dmem_we`=`is_store`.
  - `dmem_ready`=1 → WB.
  - Timeout → FAULT, code 10.
- WB: `en_exe_pulse`=1; `instret_cnt`+1.
  - `run`=1 → FETCH.
  - Else → IDLE.
- HALTED and FAULT are absorbing; only `reset` exits them. `halted`/`fault` stay high while in these states.
- Wait counter: clears on entry to FETCH or MEM, and increments each cycle ready is low. Ready sampled high in any of the first `MEM_WAIT_MAX` cycles is accepted. `MEM_WAIT_MAX` consecutive low cycles → FAULT on the next edge. Counter width is clog2(MEM_WAIT_MAX+1).
- `run` deasserted mid-instruction: the instruction completes through WB, then the FSM goes to IDLE. `run` is only sampled in IDLE and WB.
- `instr` changes only on FETCH acceptance.
- `cycle_cnt` increments every cycle not in reset; both counters wrap modulo 2^CNT_W.

## Timing
- Reset values: `state`=IDLE; `instr`=0; `fault_code`=00; counters=0; all 1-bit outputs 0.
- Reset mid-operation: all of the above on the next edge. Requests drop immediately with the state; an in-flight memory access is abandoned.
- All outputs are registered or decoded from `state` only. There is no combinational path from any input to any output.
- Zero-wait memory (ready high in the first FETCH/MEM cycle):
  - ALU instruction: 4 cycles FETCH→WB.
  - Load/store: 5 cycles.
  - Each wait cycle adds 1.
- `en_fetch_pulse` occurs exactly 1 cycle after FETCH acceptance. `en_exe_pulse` occurs exactly once per retired instruction.
- Back-to-back: FETCH of the next instruction directly follows WB. No bubble cycle.

## Configuration
- `PHASE_PERF_CNT_EN` defined: `cycle_cnt` and `instret_cnt` are implemented as specified.
- Not defined: both counters and their logic are removed; outputs are tied to 0. FSM behaviour and timing are identical.

## Test plan
- Reset, `run`=1, memories always ready, ALU instr 0x00000033 → `en_fetch_pulse` at cycle 2, `en_exe_pulse` at cycle 4, next FETCH at cycle 5; `instret_cnt`=1.
- Load with `dmem_ready` low 3 cycles → MEM lasts 4 cycles, `dmem_we`=0 throughout, instruction total 8 cycles, one `en_exe_pulse`.
- `MEM_WAIT_MAX`=15, `imem_ready` held low → FAULT after 15 FETCH cycles, `fault_code`=01. A later `imem_ready`=1 has no effect; `reset` returns to IDLE with all outputs 0.
- `is_halt`=1 with `is_illegal`=1 in DECODE → FAULT code 11. `is_halt` alone → HALTED, `halted`=1, no `en_exe_pulse`.
- `run` dropped during EXEC of a store → store completes, `en_exe_pulse` once, then IDLE. Reasserting `run` resumes FETCH on the next cycle.
- `reset` asserted in MEM with `dmem_req`=1 → next cycle `dmem_req`=0, `state`=IDLE, counters 0. Repeat with `PHASE_PERF_CNT_EN` undefined → counters always 0.
